// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared definitions for the two-requester ALU arbiter: requester count and
// ID width, lock FSM state encodings, lock counter width, the ALU opcode
// constants that requesters and benches share, and the request/response
// structs used inside the arbiter.
package alu_arbiter_pkg;

  localparam int NUM_REQ    = 2;
  localparam int REQ_ID_W   = 1;
  localparam int DATA_W     = 32;
  localparam int OPC_W      = 5;
  localparam int LOCK_CNT_W = 4;   // holds MAX_LOCK up to 15

  // Lock FSM states
  localparam logic ST_ARB    = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  // ALU opcodes
  localparam logic [OPC_W-1:0] OP_ADD = 5'b00000;
  localparam logic [OPC_W-1:0] OP_SUB = 5'b00001;
  localparam logic [OPC_W-1:0] OP_AND = 5'b00010;
  localparam logic [OPC_W-1:0] OP_OR  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SLL = 5'b00100;
  localparam logic [OPC_W-1:0] OP_SRA = 5'b00101;

  typedef struct packed {
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [OPC_W-1:0]  opcode;
    logic [OPC_W-1:0]  shamt;
  } req_t;

  typedef struct packed {
    logic [REQ_ID_W-1:0] id;
    logic [DATA_W-1:0]   result;
    logic                ne;
    logic                lt;
    logic                ovf;
  } resp_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// rr_grant2
// Combinational 2-way round-robin picker.
//   req         : per-requester request bits
//   last_grant  : requester granted most recently; loses a tie
//   enable      : no grant at all when low (downstream cannot accept)
//   force_owner : the only requester eligible while force_en is high
//   force_en    : restrict the grant to force_owner (bus lock)
//   grant       : one-hot (or zero) grant vector
module rr_grant2
  import alu_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_grant,
  input  logic               enable,
  input  logic               force_owner,
  input  logic               force_en,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    if (enable) begin
      if (force_en)
        grant[force_owner] = req[force_owner];
      else if (req == 2'b11)
        grant[!last_grant] = 1'b1;
      else
        grant = req;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one external combinational ALU between two requesters
// (0 = execute stage, 1 = auxiliary unit). Round-robin arbitration with
// valid/ready per requester, an optional bounded bus lock, and a single
// response holding register tagged with the requester ID.
//
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-low reset
//   req_valid/req_lock      : per-requester valid and lock request
//   req_op*_0/1             : operands, opcode and shift amount per requester
//   req_ready               : per-requester accept
//   alu_opA/opB/opcode/shamt: combinational drive to the shared ALU
//   alu_result/ne/lt/ovf    : ALU outputs, captured on a transfer
//   resp_*                  : registered response, handshake with resp_ready
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_lock,
  input  logic [31:0] req_opA_0,
  input  logic [31:0] req_opA_1,
  input  logic [31:0] req_opB_0,
  input  logic [31:0] req_opB_1,
  input  logic [4:0]  req_opcode_0,
  input  logic [4:0]  req_opcode_1,
  input  logic [4:0]  req_shamt_0,
  input  logic [4:0]  req_shamt_1,
  output logic [1:0]  req_ready,
  output logic [31:0] alu_opA,
  output logic [31:0] alu_opB,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_ne,
  input  logic        alu_lt,
  input  logic        alu_ovf,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_ne,
  output logic        resp_lt,
  output logic        resp_ovf,
  input  logic        resp_ready
);

  localparam logic [LOCK_CNT_W-1:0] MAX_CNT = LOCK_CNT_W'(MAX_LOCK);

  req_t                  req_s [NUM_REQ];
  resp_t                 resp_q;
  logic                  resp_vld_q;

  logic                  state_q, state_d;
  logic                  owner_q, owner_d;
  logic [LOCK_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic                  idle_q, idle_d;
  logic                  last_grant_q;

  logic                  can_issue;
  logic [NUM_REQ-1:0]    grant, xfer;
  logic                  xfer_any, gid, sel;

  assign req_s[0] = '{opa: req_opA_0, opb: req_opB_0, opcode: req_opcode_0, shamt: req_shamt_0};
  assign req_s[1] = '{opa: req_opA_1, opb: req_opB_1, opcode: req_opcode_1, shamt: req_shamt_1};

  // Holding register is empty or being drained this cycle.
  assign can_issue = !resp_vld_q || resp_ready;

  rr_grant2 u_pick (
    .req         (req_valid),
    .last_grant  (last_grant_q),
    .enable      (can_issue),
    .force_owner (owner_q),
    .force_en    (state_q == ST_LOCKED),
    .grant       (grant)
  );

  // Output process: while locked the owner sees ready whenever the holding
  // register can accept, even if it is idle; the other requester is shut out.
  always_comb begin
    req_ready = grant;
    if (state_q == ST_LOCKED) begin
      req_ready          = '0;
      req_ready[owner_q] = can_issue;
    end
  end

  assign xfer     = req_valid & req_ready;
  assign xfer_any = |xfer;
  assign gid      = xfer[1];
  // With no transfer the mux parks on last_grant so the ALU inputs stay defined.
  assign sel      = xfer_any ? gid : last_grant_q;

  assign alu_opA    = req_s[sel].opa;
  assign alu_opB    = req_s[sel].opb;
  assign alu_opcode = req_s[sel].opcode;
  assign alu_shamt  = req_s[sel].shamt;

  assign cnt_inc = cnt_q + 1'b1;

  // Next-state process. lock_cnt counts consecutive grants to the owner,
  // including the one that took the lock; the grant that brings it to
  // MAX_LOCK is the last one and hands the bus back. With MAX_LOCK == 1 the
  // lock therefore never engages.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    if (xfer_any) begin
      idle_d = 1'b0;
      if (state_q == ST_ARB) begin
        if (req_lock[gid] && (MAX_CNT > 1)) begin
          state_d = ST_LOCKED;
          owner_d = gid;
          cnt_d   = 1;
        end
      end else if (!req_lock[gid] || (cnt_inc >= MAX_CNT)) begin
        state_d = ST_ARB;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end else if (state_q == ST_LOCKED) begin
      // Idle release after two consecutive cycles without owner valid.
      if (req_valid[owner_q]) begin
        idle_d = 1'b0;
      end else if (idle_q) begin
        state_d = ST_ARB;
        cnt_d   = '0;
        idle_d  = 1'b0;
      end else begin
        idle_d = 1'b1;
      end
    end
  end

  // State register process. last_grant = g on every transfer, which also
  // covers the forced hand-over: the previous owner loses the next tie.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_ARB;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      idle_q       <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      if (xfer_any)
        last_grant_q <= gid;
    end
  end

  // Response holding register: a new transfer wins over a drain, so a drain
  // and a load in the same cycle keep valid high (one op per cycle).
  always_ff @(posedge clock) begin
    if (!reset) begin
      resp_vld_q <= 1'b0;
      resp_q     <= '0;
    end else if (xfer_any) begin
      resp_vld_q <= 1'b1;
      resp_q     <= '{id: gid, result: alu_result, ne: alu_ne, lt: alu_lt, ovf: alu_ovf};
    end else if (resp_ready) begin
      resp_vld_q <= 1'b0;
    end
  end

  assign resp_valid  = resp_vld_q;
  assign resp_id     = resp_q.id;
  assign resp_result = resp_q.result;
  assign resp_ne     = resp_q.ne;
  assign resp_lt     = resp_q.lt;
  assign resp_ovf    = resp_q.ovf;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_valid = '0, req_lock = '0, req_ready;
  logic [31:0] op_a [2], op_b [2];
  logic [4:0]  op_c [2], op_s [2];
  logic [31:0] alu_opA, alu_opB, alu_result;
  logic [4:0]  alu_opcode, alu_shamt;
  logic        alu_ne, alu_lt, alu_ovf;
  logic        resp_valid, resp_id, resp_ne, resp_lt, resp_ovf;
  logic [31:0] resp_result;
  logic        resp_ready = 1'b0;

  resp_t exp_r [2];
  resp_t q [$];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  alu_arbiter #(.MAX_LOCK(4)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
    .req_opA_0(op_a[0]), .req_opA_1(op_a[1]), .req_opB_0(op_b[0]), .req_opB_1(op_b[1]),
    .req_opcode_0(op_c[0]), .req_opcode_1(op_c[1]), .req_shamt_0(op_s[0]), .req_shamt_1(op_s[1]),
    .req_ready(req_ready), .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opcode(alu_opcode),
    .alu_shamt(alu_shamt), .alu_result(alu_result), .alu_ne(alu_ne), .alu_lt(alu_lt),
    .alu_ovf(alu_ovf), .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result),
    .resp_ne(resp_ne), .resp_lt(resp_lt), .resp_ovf(resp_ovf), .resp_ready(resp_ready)
  );

  // Stand-in for the shared combinational ALU.
  always_comb begin
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (alu_opcode)
      OP_ADD: begin
        alu_result = alu_opA + alu_opB;
        alu_ovf    = (alu_opA[31] == alu_opB[31]) && (alu_result[31] != alu_opA[31]);
      end
      OP_SUB: begin
        alu_result = alu_opA - alu_opB;
        alu_ovf    = (alu_opA[31] != alu_opB[31]) && (alu_result[31] != alu_opA[31]);
      end
      OP_AND:  alu_result = alu_opA & alu_opB;
      OP_OR:   alu_result = alu_opA | alu_opB;
      OP_SLL:  alu_result = alu_opA << alu_shamt;
      OP_SRA:  alu_result = $unsigned($signed(alu_opA) >>> alu_shamt);
      default: alu_result = '0;
    endcase
    alu_ne = (alu_opA != alu_opB);
    alu_lt = ($signed(alu_opA) < $signed(alu_opB));
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, req);
  endfunction

  // Scoreboard monitor: every accepted response is compared to the oldest expected one.
  always @(negedge clock) begin
    if (reset && resp_valid && resp_ready) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL resp_unexpected: got id=%0d result=%h, want none", resp_id, resp_result);
      end else begin
        chk("resp", 64'({resp_id, resp_result, resp_ne, resp_lt, resp_ovf}), 64'(q.pop_front()));
      end
    end
  end

  task automatic set_op(input int i, input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s, input logic [31:0] r, input logic ne, input logic lt,
                        input logic ov);
    op_c[i] = o; op_a[i] = a; op_b[i] = b; op_s[i] = s;
    exp_r[i] = '{id: 1'(i), result: r, ne: ne, lt: lt, ovf: ov};
  endtask

  task automatic step(input logic [1:0] v, input logic [1:0] lk, input logic rr,
                      input logic [1:0] er, input string nm);
    req_valid = v; req_lock = lk; resp_ready = rr;
    @(negedge clock);
    chk({nm, "_rdy"}, 64'(req_ready), 64'(er));
    for (int i = 0; i < 2; i++)
      if (v[i] && er[i]) q.push_back(exp_r[i]);
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; req_valid = '0; req_lock = '0; resp_ready = 1'b0;
    q.delete();
    @(posedge clock); #1;
    chk("rst_valid",  64'(resp_valid), 64'(0));
    chk("rst_id",     64'(resp_id), 64'(0));
    chk("rst_result", 64'(resp_result), 64'(0));
    chk("rst_flags",  64'({resp_ne, resp_lt, resp_ovf}), 64'(0));
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    set_op(0, OP_SUB, 32'd7, 32'd9, 5'd0, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0);
    set_op(1, OP_ADD, 32'd3, 32'd4, 5'd0, 32'd7, 1'b1, 1'b1, 1'b0);
    do_reset();

    // Single request
    step(2'b01, 2'b00, 1'b1, 2'b01, "single");
    step(2'b00, 2'b00, 1'b1, 2'b00, "single_idle");

    // Contention fairness from reset: 0,1,0,1
    do_reset();
    step(2'b11, 2'b00, 1'b1, 2'b01, "rr0");
    step(2'b11, 2'b00, 1'b1, 2'b10, "rr1");
    step(2'b11, 2'b00, 1'b1, 2'b01, "rr2");
    step(2'b11, 2'b00, 1'b1, 2'b10, "rr3");
    step(2'b00, 2'b00, 1'b1, 2'b00, "rr_idle");

    // Backpressure
    set_op(0, OP_OR, 32'd5, 32'd5, 5'd0, 32'd5, 1'b0, 1'b0, 1'b0);
    step(2'b01, 2'b00, 1'b0, 2'b01, "bp_load");
    step(2'b11, 2'b00, 1'b0, 2'b00, "bp_stall0");
    chk("bp_hold_v", 64'(resp_valid), 64'(1));
    chk("bp_hold_r", 64'(resp_result), 64'(5));
    step(2'b11, 2'b00, 1'b0, 2'b00, "bp_stall1");
    chk("bp_hold_r2", 64'(resp_result), 64'(5));
    step(2'b11, 2'b00, 1'b1, 2'b10, "bp_release");
    step(2'b01, 2'b00, 1'b1, 2'b01, "bp_next");
    step(2'b00, 2'b00, 1'b1, 2'b00, "bp_idle");

    // Lock bound: 4 consecutive grants to 1, then 0
    set_op(0, OP_SLL, 32'd1, 32'd0, 5'd4, 32'h10, 1'b1, 1'b0, 1'b0);
    set_op(1, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b1, 1'b1, 1'b0);
    step(2'b10, 2'b10, 1'b1, 2'b10, "lk_g1");
    step(2'b11, 2'b10, 1'b1, 2'b10, "lk_g2");
    step(2'b11, 2'b10, 1'b1, 2'b10, "lk_g3");
    step(2'b11, 2'b10, 1'b1, 2'b10, "lk_g4");
    step(2'b11, 2'b10, 1'b1, 2'b01, "lk_handover");
    step(2'b11, 2'b10, 1'b1, 2'b10, "lk_relock");
    step(2'b00, 2'b00, 1'b1, 2'b10, "lk_idle0");
    step(2'b00, 2'b00, 1'b1, 2'b10, "lk_idle1");
    step(2'b00, 2'b00, 1'b1, 2'b00, "lk_free");

    // Idle release: owner 0 idles two cycles, 1 granted on the third
    set_op(0, OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    set_op(1, OP_SRA, 32'h8000_0000, 32'd0, 5'd4, 32'hF800_0000, 1'b1, 1'b1, 1'b0);
    step(2'b01, 2'b01, 1'b1, 2'b01, "ir_lock");
    step(2'b10, 2'b00, 1'b1, 2'b01, "ir_idle0");
    step(2'b10, 2'b00, 1'b1, 2'b01, "ir_idle1");
    step(2'b10, 2'b00, 1'b1, 2'b10, "ir_grant1");
    step(2'b00, 2'b00, 1'b1, 2'b00, "ir_idle");

    // Reset while locked by 1 with a pending response
    set_op(0, OP_SUB, 32'd7, 32'd9, 5'd0, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0);
    set_op(1, OP_ADD, 32'd3, 32'd4, 5'd0, 32'd7, 1'b1, 1'b1, 1'b0);
    step(2'b10, 2'b10, 1'b0, 2'b10, "mr_lock");
    do_reset();
    step(2'b11, 2'b00, 1'b1, 2'b01, "mr_tie");
    step(2'b11, 2'b00, 1'b1, 2'b10, "mr_next");
    step(2'b00, 2'b00, 1'b1, 2'b00, "mr_idle");

    chk("sb_empty", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU instance between two requesters (0 = pipeline execute stage, 1 = auxiliary unit such as the game-logic coprocessor).
- Round-robin arbitration with valid/ready handshakes on each request port.
- Optional bounded bus lock so one requester can issue back-to-back operations.
- Drives the ALU operand/control inputs combinationally from the granted request, then registers the ALU outputs into a single response holding register tagged with the requester ID.

Parameters:
- MAX_LOCK, 4, maximum consecutive grants one requester may hold via lock before a forced hand-over (range 1..15).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  2  per-requester request valid, bit i = requester i
- req_lock  in  2  per-requester lock request, sampled only with an accepted request
- req_opA_0, req_opA_1  in  32  operand A per requester
- req_opB_0, req_opB_1  in  32  operand B per requester
- req_opcode_0, req_opcode_1  in  5  ALU opcode per requester
- req_shamt_0, req_shamt_1  in  5  shift amount per requester
- req_ready  out  2  per-requester accept; a transfer occurs when req_valid[i] and req_ready[i] are both high
- alu_opA, alu_opB  out  32  to ALU data_operandA/B
- alu_opcode, alu_shamt  out  5  to ALU ctrl_ALUopcode/ctrl_shiftamt
- alu_result  in  32  from ALU data_result
- alu_ne, alu_lt, alu_ovf  in  1  from ALU isNotEqual/isLessThan/overflow
- resp_valid  out  1  response holding register valid
- resp_id  out  1  requester that owns the response
- resp_result  out  32  registered ALU result
- resp_ne, resp_lt, resp_ovf  out  1  registered flags
- resp_ready  in  1  consumer accepts the response

Behaviour:
- Reset (reset low at a rising edge):
  - resp_valid=0, resp_id=0, resp_result=0, flags=0.
  - last_grant=1, so requester 0 wins the first tie.
  - State=ARB, lock_cnt=0, lock_owner=0.
  - Reset overrides any in-flight request or response; that data is dropped.
- can_issue = !resp_valid || resp_ready. The holding register is free or is draining this cycle.
- State ARB:
  - If can_issue and only one req_valid bit is high, grant that requester.
  - If both are high, grant !last_grant.
  - req_ready[g]=1 for the granted requester only. Grants are all-or-none; req_ready is 0 for both when !can_issue.
- State LOCKED:
  - Only lock_owner may be granted.
  - The other requester's req_ready=0 even if the owner is idle.
  - The owner's req_ready = can_issue.
- ALU drive:
  - alu_* outputs mux the granted requester's fields.
  - When there is no grant, alu_* = requester last_grant's fields. This is don't-care, but it must be stable with no X.
- Latency: a transfer in cycle N sets resp_valid=1 at edge N+1, with resp_id=g and result/flags captured from the ALU in cycle N.
- Response register update:
  - resp_ready && resp_valid with no new transfer: resp_valid clears to 0.
  - Drain and transfer in the same cycle: the new data loads and resp_valid stays 1. Full throughput is one op per cycle.
- last_grant updates to g on every transfer.
- Lock FSM (transfer by g):
  - ARB with req_lock[g]=1: go to LOCKED, lock_owner=g, lock_cnt=1.
  - LOCKED with req_lock=1 and lock_cnt<MAX_LOCK: lock_cnt increments.
  - LOCKED with req_lock=0: return to ARB.
  - lock_cnt==MAX_LOCK at a transfer: force a return to ARB regardless of req_lock, and set last_grant=g so the other requester wins the next tie.
  - LOCKED with owner req_valid low for 2 consecutive cycles: return to ARB (idle release). An idle counter resets on every owner transfer.
- Overflow flag: registered as supplied by the ALU for every opcode. The arbiter does not interpret opcodes.
- Requests must hold stable while valid and not ready. The arbiter does not check this.

Decomposition:
- Shared package: requester ID width, localparams ST_ARB/ST_LOCKED, and the ALU opcode constants (ADD=5'b00000, SUB=5'b00001, AND=5'b00010, OR=5'b00011, SLL=5'b00100, SRA=5'b00101) so requesters and benches agree.
- One natural sub-module: rr_grant2, the combinational 2-way round-robin picker taking req[1:0], last_grant, enable, force_owner and force_en, and producing grant[1:0].

Test Plan:
- Single request: req_valid=01, SUB opA=7, opB=9, resp_ready=1. Expect req_ready=01 in cycle 0; in cycle 1 resp_valid=1, resp_id=0, resp_result=0xFFFFFFFE, resp_lt=1, resp_ne=1.
- Contention fairness: both valid for 4 cycles, resp_ready=1. Expect grants 0,1,0,1 after reset and four responses with alternating resp_id.
- Backpressure: resp_ready=0 with a response pending and both requests valid. Expect req_ready=00 and the response held constant. Raise resp_ready, and the next grant plus data load happen in that same cycle.
- Lock bound with MAX_LOCK=4: requester 1 holds lock and valid for 6 cycles while requester 0 is valid. Expect 4 consecutive grants to 1, then a grant to 0.
- Idle release: requester 0 locks, then drops valid for 2 cycles while requester 1 is valid. Expect requester 1 granted in the third cycle.
- Reset mid-operation: assert reset with resp_valid=1 and LOCKED. Expect resp_valid=0, state ARB, and the first tie after release granted to requester 0.
